// File: rtl/peak_pkg.sv
// Shared types and constants for the peak/min tracker.
package peak_pkg;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/peak_tracker_cmp.sv
// Unsigned magnitude comparator reused for the running max and min checks.
module peak_tracker_cmp
  import peak_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic         lt
);
  assign gt = (a > b);
  assign lt = (a < b);
endmodule

// File: rtl/peak_tracker.sv
// Tracks largest and smallest unsigned sample over a window of WINDOW accepted samples.
//   state    | meaning
//   ST_IDLE  | waiting for start; last window's results held
//   ST_TRACK | accepting samples, busy high
//   ST_DONE  | window complete, done pulses for one cycle
module peak_tracker
  import peak_pkg::*;
#(
  parameter int WINDOW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              start,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] max_val,
  output logic [DATA_W-1:0] min_val,
  output logic [7:0]        sample_count
);
  localparam logic [7:0] WIN_CNT = 8'(WINDOW);

  state_t            state, state_nx;
  logic [DATA_W-1:0] max_nx, min_nx;
  logic [7:0]        count_nx, count_inc;
  logic              gt_max, lt_min, accept, first;

  peak_tracker_cmp #(.W(DATA_W)) u_cmp_max (
    .a (sample_data),
    .b (max_val),
    .gt(gt_max),
    .lt()
  );

  peak_tracker_cmp #(.W(DATA_W)) u_cmp_min (
    .a (sample_data),
    .b (min_val),
    .gt(),
    .lt(lt_min)
  );

  assign accept    = (state == ST_TRACK) && sample_valid;
  assign first     = (sample_count == 8'd0);
  assign count_inc = sample_count + 8'd1;

  always_comb begin
    state_nx = state;
    max_nx   = max_val;
    min_nx   = min_val;
    count_nx = sample_count;
    if (clear) begin
      state_nx = ST_IDLE;
      max_nx   = '0;
      min_nx   = '0;
      count_nx = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nx = ST_TRACK;
            count_nx = '0;
          end
        end
        ST_TRACK: begin
          if (accept) begin
            count_nx = count_inc;
            // First sample seeds both extremes regardless of stale results.
            if (first || gt_max) max_nx = sample_data;
            if (first || lt_min) min_nx = sample_data;
            if (count_inc == WIN_CNT) state_nx = ST_DONE;
          end
        end
        ST_DONE: state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      max_val      <= '0;
      min_val      <= '0;
      sample_count <= '0;
    end else begin
      state        <= state_nx;
      busy         <= (state_nx == ST_TRACK);
      done         <= (state_nx == ST_DONE);
      max_val      <= max_nx;
      min_val      <= min_nx;
      sample_count <= count_nx;
    end
  end
endmodule

// File: tb/tb_peak_tracker.sv
// Directed bench for peak_tracker with WINDOW=4 and hand-computed expectations.
module tb_peak_tracker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic        busy, done;
  logic [15:0] max_val, min_val;
  logic [7:0]  sample_count;

  int total = 0;
  int bad = 0;

  peak_tracker #(.WINDOW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .start       (start),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .busy        (busy),
    .done        (done),
    .max_val     (max_val),
    .min_val     (min_val),
    .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic b, input logic d,
                         input logic [15:0] mx, input logic [15:0] mn, input logic [7:0] c);
    chk({tag, ".busy"}, 16'(busy), 16'(b));
    chk({tag, ".done"}, 16'(done), 16'(d));
    chk({tag, ".max"}, max_val, mx);
    chk({tag, ".min"}, min_val, mn);
    chk({tag, ".cnt"}, 16'(sample_count), 16'(c));
  endtask

  initial begin
    #12;
    chk_all("reset", 1'b0, 1'b0, 16'd0, 16'd0, 8'd0);
    rst = 1'b0;
    step();

    // basic window 5,300,2,300
    start = 1'b1; step(); start = 1'b0;
    chk_all("t1.start", 1'b1, 1'b0, 16'd0, 16'd0, 8'd0);
    feed(16'd5);
    chk_all("t1.s1", 1'b1, 1'b0, 16'd5, 16'd5, 8'd1);
    feed(16'd300);
    feed(16'd2);
    chk_all("t1.s3", 1'b1, 1'b0, 16'd300, 16'd2, 8'd3);
    feed(16'd300);
    chk_all("t1.done", 1'b0, 1'b1, 16'd300, 16'd2, 8'd4);
    step();
    chk_all("t1.idle", 1'b0, 1'b0, 16'd300, 16'd2, 8'd4);
    feed(16'd999);
    chk_all("t1.idle_ign", 1'b0, 1'b0, 16'd300, 16'd2, 8'd4);

    // equal samples, sample during DONE ignored
    start = 1'b1; step(); start = 1'b0;
    chk_all("t2.start", 1'b1, 1'b0, 16'd300, 16'd2, 8'd0);
    repeat (4) feed(16'h8000);
    chk_all("t2.done", 1'b0, 1'b1, 16'h8000, 16'h8000, 8'd4);
    feed(16'hFFFF);
    chk_all("t2.post", 1'b0, 1'b0, 16'h8000, 16'h8000, 8'd4);

    // extremes with gaps, start ignored during TRACK
    start = 1'b1; step(); start = 1'b0;
    feed(16'h0000);
    step(); step();
    start = 1'b1;
    feed(16'hFFFF);
    start = 1'b0;
    step();
    chk_all("t3.gap", 1'b1, 1'b0, 16'hFFFF, 16'h0000, 8'd2);
    feed(16'd1);
    feed(16'd1);
    chk_all("t3.done", 1'b0, 1'b1, 16'hFFFF, 16'h0000, 8'd4);
    step();

    // clear with simultaneous sample
    start = 1'b1; step(); start = 1'b0;
    feed(16'd10);
    feed(16'd20);
    clear = 1'b1;
    feed(16'd50);
    clear = 1'b0;
    chk_all("t4.clear", 1'b0, 1'b0, 16'd0, 16'd0, 8'd0);
    step();
    chk_all("t4.after", 1'b0, 1'b0, 16'd0, 16'd0, 8'd0);

    // async reset mid-window
    start = 1'b1; step(); start = 1'b0;
    feed(16'd3);
    feed(16'd4);
    rst = 1'b1;
    #1;
    chk_all("t5.rst", 1'b0, 1'b0, 16'd0, 16'd0, 8'd0);
    #1 rst = 1'b0;
    step();
    chk_all("t5.rel", 1'b0, 1'b0, 16'd0, 16'd0, 8'd0);
    start = 1'b1; step(); start = 1'b0;
    feed(16'd9);
    feed(16'd9);
    feed(16'd1);
    feed(16'd7);
    chk_all("t5.done", 1'b0, 1'b1, 16'd9, 16'd1, 8'd4);
    step();
    chk("t5.pulse", 16'(done), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
